// File: rtl/exec_pkg.sv
// Shared types and constants for the execute-stage issue/hazard controller.
package exec_pkg;

  // Register address width; the writeback slot type is built on it.
  localparam int EXEC_AW = 4;

  // issue_unit encoding.
  localparam logic UNIT_ALU = 1'b0;
  localparam logic UNIT_FPU = 1'b1;

  // One pending regfile write: valid plus destination register.
  typedef struct packed {
    logic               v;
    logic [EXEC_AW-1:0] addr;
  } wb_slot_t;

endpackage

// File: rtl/fpu_track_pipe.sv
// Shadow of the FPU pipeline: one slot per cycle of latency plus an
// in-flight op counter. Slot 0 is the slot writing back this cycle.
module fpu_track_pipe
  import exec_pkg::*;
#(
  parameter int FPU_LAT = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push_i,       // FPU op accepted this cycle
  input  wb_slot_t push_slot_i,  // its write intent (v=0 for non-writing ops)
  output wb_slot_t slot0_o,
  output wb_slot_t slot1_o,
  output logic     busy_o
);

  localparam int CW = $clog2(FPU_LAT + 1);

  wb_slot_t [FPU_LAT-1:0] slot_q;
  // Occupancy is tracked apart from v so non-writing FPU ops still count.
  logic     [FPU_LAT-1:0] occ_q, occ_d;
  logic     [CW-1:0]      inflight_q, inflight_d;

  // Next occupancy: shift toward slot 0, new op enters the top slot.
  always_comb begin
    occ_d              = occ_q >> 1;
    occ_d[FPU_LAT-1]   = push_i;
  end

  // Count ops entering minus ops leaving slot 0; both at once cancel.
  always_comb begin
    inflight_d = inflight_q;
    if (push_i && !occ_q[0])      inflight_d = inflight_q + CW'(1);
    else if (!push_i && occ_q[0]) inflight_d = inflight_q - CW'(1);
  end

  // Slot shift register and counter; reset discards everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q     <= '0;
      occ_q      <= '0;
      inflight_q <= '0;
    end else begin
      for (int i = 0; i < FPU_LAT - 1; i++) slot_q[i] <= slot_q[i+1];
      slot_q[FPU_LAT-1] <= push_i ? push_slot_i : '0;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
    end
  end

  assign slot0_o = slot_q[0];
  assign busy_o  = (inflight_q != '0);

  // Slot 1 only exists when results take two or more cycles.
  generate
    if (FPU_LAT >= 2) begin : g_slot1
      assign slot1_o = slot_q[1];
    end else begin : g_no_slot1
      assign slot1_o = '0;
    end
  endgenerate

endmodule

// File: rtl/exec_hazard_ctrl.sv
// Issue/hazard controller between decode and execute/writeback. Tracks
// multi-cycle FPU results in a register scoreboard, arbitrates the single
// regfile write port and drives operand forward selects.
module exec_hazard_ctrl
  import exec_pkg::*;
#(
  parameter int FPU_LAT       = 2,  // 1..8
  parameter int FPU_PIPELINED = 0,
  localparam int AW           = EXEC_AW
) (
  input  logic          clk,
  input  logic          reset,          // async, active low
  input  logic          issue_valid,
  input  logic          issue_unit,
  input  logic          issue_wr_en,
  input  logic [AW-1:0] issue_wr_addr,
  input  logic [AW-1:0] issue_rs1,
  input  logic          issue_rs1_used,
  input  logic [AW-1:0] issue_rs2,
  input  logic          issue_rs2_used,
  output logic          issue_ready,
  output logic          fwd1_sel,
  output logic          fwd2_sel,
  output logic          fpu_start,
  output logic          fpu_busy,
  output logic          wb_en,
  output logic [AW-1:0] wb_addr,
  output logic          wb_src
);

  localparam int NREGS = 2 ** AW;

  wb_slot_t         alu_q, alu_d;
  wb_slot_t         slot0, slot1, push_slot;
  logic [NREGS-1:0] pend_q, pend_d;
  logic             raw1, raw2, waw, port_conf, fpu_struct;

  assign push_slot = '{v: issue_wr_en, addr: issue_wr_addr};

  fpu_track_pipe #(.FPU_LAT(FPU_LAT)) u_fpu_track (
    .clk         (clk),
    .rst_n       (reset),
    .push_i      (fpu_start),
    .push_slot_i (push_slot),
    .slot0_o     (slot0),
    .slot1_o     (slot1),
    .busy_o      (fpu_busy)
  );

  // Writeback port: FPU slot 0 has priority; stalls keep ALU out of its way.
  always_comb begin
    wb_en   = slot0.v | alu_q.v;
    wb_src  = slot0.v;
    wb_addr = '0;
    if (slot0.v)      wb_addr = slot0.addr;
    else if (alu_q.v) wb_addr = alu_q.addr;
  end

  // Hazard detection. A source that slot 0 is writing right now is served
  // by the forward path, so it is not a RAW hazard.
  always_comb begin
    raw1       = issue_rs1_used && pend_q[issue_rs1] &&
                 !(slot0.v && slot0.addr == issue_rs1);
    raw2       = issue_rs2_used && pend_q[issue_rs2] &&
                 !(slot0.v && slot0.addr == issue_rs2);
    waw        = issue_wr_en && pend_q[issue_wr_addr];
    port_conf  = (issue_unit == UNIT_ALU) && issue_wr_en && slot1.v;
    fpu_struct = (issue_unit == UNIT_FPU) && (FPU_PIPELINED == 0) && fpu_busy;
    issue_ready = reset && issue_valid &&
                  !(raw1 || raw2 || waw || port_conf || fpu_struct);
  end

  assign fpu_start = issue_ready && (issue_unit == UNIT_FPU);

  // Regfile writes land at end of cycle, so a same-cycle read takes the bus.
  assign fwd1_sel = issue_rs1_used && wb_en && (wb_addr == issue_rs1);
  assign fwd2_sel = issue_rs2_used && wb_en && (wb_addr == issue_rs2);

  // ALU stage and scoreboard next state; a set beats a same-edge clear.
  always_comb begin
    alu_d = '0;
    if (issue_ready && issue_unit == UNIT_ALU) alu_d = push_slot;
    pend_d = pend_q;
    if (slot0.v) pend_d[slot0.addr] = 1'b0;
    if (fpu_start && issue_wr_en) pend_d[issue_wr_addr] = 1'b1;
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_q  <= '0;
      pend_q <= '0;
    end else begin
      alu_q  <= alu_d;
      pend_q <= pend_d;
    end
  end

endmodule

// File: tb/tb_exec_hazard_ctrl.sv
// Bench for exec_hazard_ctrl. Three instances with different FPU configs
// share clock and reset; only one is driven at a time. Expected writebacks
// go into a scoreboard queue that a negedge monitor drains.
module tb_exec_hazard_ctrl;
  import exec_pkg::*;

  localparam int ND = 3;
  // dut0: LAT 2 blocking, dut1: LAT 3 blocking, dut2: LAT 2 pipelined
  localparam logic [ND-1:0][3:0] LAT  = {4'd2, 4'd3, 4'd2};
  localparam logic [ND-1:0]      PIPE = 3'b100;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         iv [ND], iu [ND], iwe [ND], u1 [ND], u2 [ND];
  logic [3:0]   iwa [ND], r1 [ND], r2 [ND];
  logic         rdy [ND], f1 [ND], f2 [ND], fst [ND], fbsy [ND], wen [ND], wsrc [ND];
  logic [3:0]   wadr [ND];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    exec_hazard_ctrl #(.FPU_LAT(int'(LAT[g])), .FPU_PIPELINED(int'(PIPE[g]))) u_dut (
      .clk(clk), .reset(rst_n),
      .issue_valid(iv[g]), .issue_unit(iu[g]), .issue_wr_en(iwe[g]),
      .issue_wr_addr(iwa[g]), .issue_rs1(r1[g]), .issue_rs1_used(u1[g]),
      .issue_rs2(r2[g]), .issue_rs2_used(u2[g]),
      .issue_ready(rdy[g]), .fwd1_sel(f1[g]), .fwd2_sel(f2[g]),
      .fpu_start(fst[g]), .fpu_busy(fbsy[g]),
      .wb_en(wen[g]), .wb_addr(wadr[g]), .wb_src(wsrc[g])
    );
  end

  typedef struct packed {
    logic [1:0] dut;
    logic [3:0] addr;
    logic       src;
  } exp_t;

  exp_t expq[$];
  exp_t e;
  int   vectors = 0;
  int   miscompares = 0;

  // Monitor: every writeback must match the oldest expected one.
  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (wen[d]) begin
        vectors++;
        if (expq.size() == 0) begin
          miscompares++;
          $display("FAIL wb_unexpected dut%0d: got addr=%0d src=%0d, expected no writeback",
                   d, wadr[d], wsrc[d]);
        end else begin
          e = expq.pop_front();
          if (e.dut != 2'(d) || e.addr != wadr[d] || e.src != wsrc[d]) begin
            miscompares++;
            $display("FAIL wb_order dut%0d: got addr=%0d src=%0d, expected dut%0d addr=%0d src=%0d",
                     d, wadr[d], wsrc[d], e.dut, e.addr, e.src);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic push_wb(input int d, input int a, input logic s);
    expq.push_back('{dut: 2'(d), addr: 4'(a), src: s});
  endtask

  task automatic idle_all();
    for (int d = 0; d < ND; d++) begin
      iv[d] = 0; iu[d] = 0; iwe[d] = 0; iwa[d] = 0;
      r1[d] = 0; u1[d] = 0; r2[d] = 0; u2[d] = 0;
    end
  endtask

  task automatic op(input int d, input logic u, input logic we, input int wa,
                    input int s1, input logic us1, input int s2, input logic us2);
    idle_all();
    iv[d] = 1; iu[d] = u; iwe[d] = we; iwa[d] = 4'(wa);
    r1[d] = 4'(s1); u1[d] = us1; r2[d] = 4'(s2); u2[d] = us2;
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. reset with a valid instruction held
    rst_n = 1'b0;
    idle_all();
    iv[0] = 1;
    repeat (2) next();
    neg();
    chk("rst_ready", rdy[0], 0);
    chk("rst_wb_en", wen[0], 0);
    chk("rst_busy",  fbsy[0], 0);
    chk("rst_start", fst[0], 0);
    next();
    rst_n = 1'b1;
    neg();
    chk("rel_ready", rdy[0], 1);
    next();
    idle_all();
    repeat (2) next();

    // 2. LAT3: FPU R2, then ALU reads R2 (writes R8)
    op(1, UNIT_FPU, 1, 2, 0, 0, 0, 0);
    neg(); chk("t2_fpu_ready", rdy[1], 1); chk("t2_fpu_start", fst[1], 1);
    push_wb(1, 2, 1);
    next();
    op(1, UNIT_ALU, 1, 8, 2, 1, 0, 0);
    neg(); chk("t2_raw_t1", rdy[1], 0); chk("t2_busy_t1", fbsy[1], 1);
    next();
    neg(); chk("t2_raw_t2", rdy[1], 0); chk("t2_fwd_t2", f1[1], 0);
    next();
    neg(); chk("t2_ready_t3", rdy[1], 1); chk("t2_wb_en_t3", wen[1], 1);
    chk("t2_fwd1_t3", f1[1], 1); chk("t2_fwd2_t3", f2[1], 0);
    push_wb(1, 8, 0);
    next();
    idle_all();
    neg(); chk("t2_busy_t4", fbsy[1], 0);
    repeat (3) next();

    // 3. LAT2: FPU R3, then ALU R5 hits the port conflict
    op(0, UNIT_FPU, 1, 3, 0, 0, 0, 0);
    neg(); chk("t3_fpu_ready", rdy[0], 1);
    push_wb(0, 3, 1);
    next();
    op(0, UNIT_ALU, 1, 5, 0, 0, 0, 0);
    neg(); chk("t3_port_t1", rdy[0], 0);
    next();
    neg(); chk("t3_ready_t2", rdy[0], 1); chk("t3_wbsrc_t2", wsrc[0], 1);
    push_wb(0, 5, 0);
    next();
    idle_all();
    repeat (3) next();

    // 4a. blocking FPU: back-to-back R1, R4
    op(0, UNIT_FPU, 1, 1, 0, 0, 0, 0);
    neg(); chk("t4a_start_t0", fst[0], 1);
    push_wb(0, 1, 1);
    next();
    op(0, UNIT_FPU, 1, 4, 0, 0, 0, 0);
    neg(); chk("t4a_struct_t1", rdy[0], 0); chk("t4a_start_t1", fst[0], 0);
    next();
    neg(); chk("t4a_struct_t2", rdy[0], 0);
    next();
    neg(); chk("t4a_ready_t3", rdy[0], 1); chk("t4a_start_t3", fst[0], 1);
    push_wb(0, 4, 1);
    next();
    idle_all();
    repeat (4) next();

    // 4b. pipelined FPU: R1, R4 on consecutive cycles
    op(2, UNIT_FPU, 1, 1, 0, 0, 0, 0);
    neg(); chk("t4b_start_t0", fst[2], 1);
    push_wb(2, 1, 1);
    next();
    op(2, UNIT_FPU, 1, 4, 0, 0, 0, 0);
    neg(); chk("t4b_start_t1", fst[2], 1);
    push_wb(2, 4, 1);
    next();
    idle_all();
    neg(); chk("t4b_busy_t2", fbsy[2], 1);
    repeat (4) next();

    // 5. WAW: FPU R6 then ALU R6
    op(0, UNIT_FPU, 1, 6, 0, 0, 0, 0);
    neg(); chk("t5_fpu_ready", rdy[0], 1);
    push_wb(0, 6, 1);
    next();
    op(0, UNIT_ALU, 1, 6, 0, 0, 0, 0);
    neg(); chk("t5_waw_t1", rdy[0], 0);
    next();
    neg(); chk("t5_waw_t2", rdy[0], 0);
    next();
    neg(); chk("t5_ready_t3", rdy[0], 1);
    push_wb(0, 6, 0);
    next();
    idle_all();
    repeat (3) next();

    // 6. reset discards an in-flight FPU R7
    op(1, UNIT_FPU, 1, 7, 0, 0, 0, 0);
    neg(); chk("t6_fpu_ready", rdy[1], 1);
    next();
    idle_all();
    #2 rst_n = 1'b0;
    neg(); chk("t6_rst_busy", fbsy[1], 0); chk("t6_rst_wb", wen[1], 0);
    next();
    rst_n = 1'b1;
    op(1, UNIT_ALU, 1, 9, 7, 1, 0, 0);
    neg(); chk("t6_r7_ready", rdy[1], 1); chk("t6_busy", fbsy[1], 0);
    push_wb(1, 9, 0);
    next();
    idle_all();
    repeat (6) next();

    chk("sb_drained", expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
